// File: rtl/cpu6_store_buffer_pkg.sv
// cpu6_store_buffer_pkg: shared types and defaults for the cpu6 data-side store buffer.
package cpu6_store_buffer_pkg;
    localparam int SBUF_DEPTH = 4;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ST_REQ  = 2'd1,
        LD_REQ  = 2'd2,
        LD_WAIT = 2'd3
    } sbuf_state_e;
endpackage

// File: rtl/cpu6_store_buffer_if.sv
// cpu6_store_buffer_if: single-outstanding request/grant data bus with separate read return.
interface cpu6_store_buffer_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;
    modport master(output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave(input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/cpu6_sbuf_fifo.sv
// cpu6_sbuf_fifo: in-order store entry storage; exposes every slot and a valid vector for forwarding.
module cpu6_sbuf_fifo #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-3:0] push_addr,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-3:0] addr_q [DEPTH],
    output logic [XLEN-1:0] data_q [DEPTH],
    output logic [DEPTH-1:0] valid,
    output logic [PTRW-1:0] head,
    output logic [PTRW:0]   count,
    output logic            full,
    output logic            empty
);
    logic [PTRW-1:0] tail;

    assign full  = count == (PTRW+1)'(DEPTH);
    assign empty = count == '0;

    // a slot is live when its distance from head is below the occupancy
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++)
            valid[i] = {1'b0, PTRW'(i) - head} < count;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTRW'(1);
            if (pop) head <= head + PTRW'(1);
            count <= count + (PTRW+1)'(push) - (PTRW+1)'(pop);
        end

    always_ff @(posedge clk)
        if (push) begin
            addr_q[tail] <= push_addr;
            data_q[tail] <= push_data;
        end
endmodule

// File: rtl/cpu6_store_buffer.sv
// cpu6_store_buffer: write buffer between the cpu6 M stage and a handshaked data bus,
// with youngest-match store-to-load forwarding and stalling load misses.
module cpu6_store_buffer
    import cpu6_store_buffer_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = SBUF_DEPTH,
    parameter int PTRW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            memwriteM,
    input  logic            memreadM,
    input  logic [XLEN-1:0] dataaddr,
    input  logic [XLEN-1:0] writedata,
    output logic [XLEN-1:0] readdata,
    output logic            stall,
    cpu6_store_buffer_if.master bus
);
    sbuf_state_e     state, state_n;
    logic [XLEN-3:0] addr_q [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PTRW-1:0] head, nxt;
    logic [PTRW:0]   count;
    logic            full, empty, push, pop, match, hit, miss, rdone;
    logic [XLEN-1:0] fwd, src_data, addr_n, wdata_n;
    logic [XLEN-3:0] src_addr;
    logic            req_n, we_n;
    logic            unused_lo;

    assign unused_lo = ^dataaddr[1:0];

    cpu6_sbuf_fifo #(.XLEN(XLEN), .DEPTH(DEPTH), .PTRW(PTRW)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .push_addr(dataaddr[XLEN-1:2]),
        .push_data(writedata),
        .addr_q(addr_q),
        .data_q(data_q),
        .valid(valid),
        .head(head),
        .count(count),
        .full(full),
        .empty(empty)
    );

    // walk oldest to youngest so the last match wins
    always_comb begin
        match = 1'b0;
        fwd   = '0;
        for (int k = 0; k < DEPTH; k++)
            if (valid[head + PTRW'(k)] && addr_q[head + PTRW'(k)] == dataaddr[XLEN-1:2]) begin
                match = 1'b1;
                fwd   = data_q[head + PTRW'(k)];
            end
    end

    assign hit      = memreadM & match;
    assign miss     = memreadM & ~match;
    assign pop      = (state == ST_REQ) & bus.gnt;
    assign rdone    = (state == LD_WAIT) & bus.rvalid;
    assign stall    = reset & ((memwriteM & full & ~pop) | (state == LD_REQ) |
                      ((state == LD_WAIT) & ~bus.rvalid) |
                      (miss & ((state == IDLE) | (state == ST_REQ))));
    assign push     = memwriteM & ~stall;
    assign readdata = rdone ? bus.rdata : hit ? fwd : '0;
    assign nxt      = head + PTRW'(1);
    // a same-cycle push lands right behind a lone head, so bypass it from the core
    assign src_addr = state != ST_REQ ? addr_q[head] :
                      count == (PTRW+1)'(1) ? dataaddr[XLEN-1:2] : addr_q[nxt];
    assign src_data = state != ST_REQ ? data_q[head] :
                      count == (PTRW+1)'(1) ? writedata : data_q[nxt];

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state     <= IDLE;
            bus.req   <= 1'b0;
            bus.we    <= 1'b0;
            bus.addr  <= '0;
            bus.wdata <= '0;
        end else begin
            state     <= state_n;
            bus.req   <= req_n;
            bus.we    <= we_n;
            bus.addr  <= addr_n;
            bus.wdata <= wdata_n;
        end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = miss ? LD_REQ : !empty ? ST_REQ : IDLE;
            ST_REQ:  state_n = !bus.gnt ? ST_REQ : miss ? LD_REQ :
                               (count > (PTRW+1)'(1) || push) ? ST_REQ : IDLE;
            LD_REQ:  state_n = bus.gnt ? LD_WAIT : LD_REQ;
            default: state_n = !bus.rvalid ? LD_WAIT : empty ? IDLE : ST_REQ;
        endcase
    end

    always_comb begin
        req_n   = state_n == LD_REQ || state_n == ST_REQ;
        we_n    = bus.we;
        addr_n  = bus.addr;
        wdata_n = bus.wdata;
        if (state_n == LD_REQ && state != LD_REQ) begin
            we_n   = 1'b0;
            addr_n = {dataaddr[XLEN-1:2], 2'b00};
        end else if (state_n == ST_REQ && (state != ST_REQ || pop)) begin
            we_n    = 1'b1;
            addr_n  = {src_addr, 2'b00};
            wdata_n = src_data;
        end
    end
endmodule
